// File: rtl/line_sensor_adc.sv
// SPI front end for the 8-channel 12-bit ADC: polls left/centre/right reflectance
// channels in rotation and turns each sweep into a hysteresis-filtered line vector.
module line_sensor_adc #(
   parameter int unsigned CLK_DIV   = 25,
   parameter logic [2:0]  CH_LEFT   = 3'd0,
   parameter logic [2:0]  CH_CENTER = 3'd1,
   parameter logic [2:0]  CH_RIGHT  = 3'd2,
   parameter logic [11:0] THRESH_HI = 12'd1800,
   parameter logic [11:0] THRESH_LO = 12'd1400,
   parameter int unsigned GAP_CYC   = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        adc_cs_n,
   output logic        adc_sck,
   output logic        adc_din,
   input  logic        adc_dout,
   output logic [2:0]  adc_data,
   output logic        sensor_valid,
   output logic [11:0] raw_left,
   output logic [11:0] raw_center,
   output logic [11:0] raw_right
);

   typedef enum logic [1:0] {S_GAP, S_FRAME, S_LATCH} state_e;

   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
   localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [5:0]    HALF_LAST  = 6'd32;
   localparam logic [5:0]    HALF_DATA0 = 6'd10;
   localparam logic [1:0]    SEL_L = 2'd0;
   localparam logic [1:0]    SEL_C = 2'd1;
   localparam logic [1:0]    SEL_R = 2'd2;

   state_e        state_q, state_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]    div_cnt_q, div_cnt_d;
   logic [5:0]    half_q, half_d;
   logic          cs_n_q, cs_n_d;
   logic          sck_q, sck_d;
   logic          din_q, din_d;
   logic          sync1_q, sync2_q;
   logic [11:0]   res_q, res_d;
   logic [1:0]    cur_sel_q, cur_sel_d;
   logic [1:0]    prev_sel_q, prev_sel_d;
   logic          dummy_q, dummy_d;
   logic [11:0]   stg_l_q, stg_l_d;
   logic [11:0]   stg_c_q, stg_c_d;
   logic [11:0]   raw_l_q, raw_l_d;
   logic [11:0]   raw_c_q, raw_c_d;
   logic [11:0]   raw_r_q, raw_r_d;
   logic [2:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic [15:0]   frame_word;

   function automatic logic [2:0] sel_addr(input logic [1:0] sel);
      case (sel)
         SEL_C:   return CH_CENTER;
         SEL_R:   return CH_RIGHT;
         default: return CH_LEFT;
      endcase
   endfunction

   function automatic logic [1:0] sel_next(input logic [1:0] sel);
      case (sel)
         SEL_L:   return SEL_C;
         SEL_C:   return SEL_R;
         default: return SEL_L;
      endcase
   endfunction

   function automatic logic hyst(input logic [11:0] raw, input logic prev);
      if (raw >= THRESH_HI)
         return 1'b1;
      else if (raw < THRESH_LO)
         return 1'b0;
      else
         return prev;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_GAP;
         gap_cnt_q  <= '0;
         div_cnt_q  <= '0;
         half_q     <= '0;
         cs_n_q     <= 1'b1;
         sck_q      <= 1'b1;
         din_q      <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         res_q      <= '0;
         cur_sel_q  <= SEL_L;
         prev_sel_q <= SEL_L;
         dummy_q    <= 1'b1;
         stg_l_q    <= '0;
         stg_c_q    <= '0;
         raw_l_q    <= '0;
         raw_c_q    <= '0;
         raw_r_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         div_cnt_q  <= div_cnt_d;
         half_q     <= half_d;
         cs_n_q     <= cs_n_d;
         sck_q      <= sck_d;
         din_q      <= din_d;
         sync1_q    <= adc_dout;
         sync2_q    <= sync1_q;
         res_q      <= res_d;
         cur_sel_q  <= cur_sel_d;
         prev_sel_q <= prev_sel_d;
         dummy_q    <= dummy_d;
         stg_l_q    <= stg_l_d;
         stg_c_q    <= stg_c_d;
         raw_l_q    <= raw_l_d;
         raw_c_q    <= raw_c_d;
         raw_r_q    <= raw_r_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      div_cnt_d  = div_cnt_q;
      half_d     = half_q;
      cs_n_d     = cs_n_q;
      sck_d      = sck_q;
      din_d      = din_q;
      cur_sel_d  = cur_sel_q;
      prev_sel_d = prev_sel_q;
      dummy_d    = dummy_q;
      stg_l_d    = stg_l_q;
      stg_c_d    = stg_c_q;
      raw_l_d    = raw_l_q;
      raw_c_d    = raw_c_q;
      raw_r_d    = raw_r_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      frame_word = {2'b00, sel_addr(cur_sel_q), 11'b0};

      // Sync delay is two clks, so sample one clk into the high half: the bit
      // taken is the one that was on adc_dout when SCK rose.
      res_d = res_q;
      if (state_q == S_FRAME && !half_q[0] && half_q >= HALF_DATA0 && div_cnt_q == 8'd1)
         res_d = {res_q[10:0], sync2_q};

      case (state_q)
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = S_FRAME;
               cs_n_d    = 1'b0;
               div_cnt_d = '0;
               half_d    = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         S_FRAME: begin
            if (div_cnt_q != DIV_LAST) begin
               div_cnt_d = div_cnt_q + 8'd1;
            end else begin
               div_cnt_d = '0;
               if (half_q == HALF_LAST) begin
                  // End of frame: result is for the channel addressed last frame.
                  state_d    = S_LATCH;
                  cs_n_d     = 1'b1;
                  din_d      = 1'b0;
                  prev_sel_d = cur_sel_q;
                  cur_sel_d  = sel_next(cur_sel_q);
                  if (dummy_q) begin
                     dummy_d = 1'b0;
                  end else begin
                     case (prev_sel_q)
                        SEL_L: stg_l_d = res_d;
                        SEL_C: stg_c_d = res_d;
                        default: begin
                           raw_l_d = stg_l_q;
                           raw_c_d = stg_c_q;
                           raw_r_d = res_d;
                           data_d  = {hyst(stg_l_q, data_q[2]),
                                      hyst(stg_c_q, data_q[1]),
                                      hyst(res_d,   data_q[0])};
                           valid_d = 1'b1;
                        end
                     endcase
                  end
               end else begin
                  half_d = half_q + 6'd1;
                  if (!half_q[0]) begin
                     sck_d = 1'b0;
                     din_d = frame_word[~half_q[4:1]];
                  end else begin
                     sck_d = 1'b1;
                  end
               end
            end
         end
         S_LATCH: begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
         end
         default: state_d = S_GAP;
      endcase
   end

   assign adc_cs_n     = cs_n_q;
   assign adc_sck      = sck_q;
   assign adc_din      = din_q;
   assign adc_data     = data_q;
   assign sensor_valid = valid_q;
   assign raw_left     = raw_l_q;
   assign raw_center   = raw_c_q;
   assign raw_right    = raw_r_q;

endmodule

// File: tb/tb_line_sensor_adc.sv
// Bench for line_sensor_adc: behavioural ADC on the SPI pins plus directed
// sweep vectors and hand-written reset / framing sequences.
module tb_line_sensor_adc;

   localparam int CLK_DIV   = 4;
   localparam int GAP_CYC   = 6;
   localparam int FRAME_CYC = 33*CLK_DIV + 1 + GAP_CYC;
   localparam int FIRST_LAT = GAP_CYC + 4*33*CLK_DIV + 3*(1 + GAP_CYC);
   localparam int NV        = 7;

   typedef struct {
      logic [11:0] l;
      logic [11:0] c;
      logic [11:0] r;
      logic [2:0]  exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        adc_dout = 1'b0;
   logic        adc_cs_n, adc_sck, adc_din, sensor_valid;
   logic [2:0]  adc_data;
   logic [11:0] raw_left, raw_center, raw_right;

   line_sensor_adc #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .adc_din(adc_din), .adc_dout(adc_dout),
      .adc_data(adc_data), .sensor_valid(sensor_valid),
      .raw_left(raw_left), .raw_center(raw_center), .raw_right(raw_right)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // ADC model: answers with the channel addressed in the previous frame
   logic [11:0] v_l = '0, v_c = '0, v_r = '0;
   logic [15:0] din_sh = '0;
   logic [15:0] srv_word = '0;
   logic [2:0]  srv_addr = '0;
   int          fall_k = 0;
   logic [2:0]  addr_log[$];

   function automatic logic [11:0] chan_val(input logic [2:0] a);
      case (a)
         3'd0:    return v_l;
         3'd1:    return v_c;
         3'd2:    return v_r;
         default: return 12'd0;
      endcase
   endfunction

   always @(negedge adc_cs_n or negedge adc_sck)
      if (adc_sck)
         fall_k <= 0;
      else if (!adc_cs_n) begin
         if (fall_k == 0) begin
            adc_dout <= 1'b0;
            srv_word <= {4'h0, chan_val(srv_addr)};
         end else if (fall_k < 16) begin
            adc_dout <= srv_word[15-fall_k];
         end
         fall_k <= fall_k + 1;
      end

   always @(posedge adc_sck)
      if (!adc_cs_n) din_sh <= {din_sh[14:0], adc_din};

   always @(posedge adc_cs_n or negedge rst_n)
      if (!rst_n)
         srv_addr <= 3'd0;
      else begin
         srv_addr <= din_sh[13:11];
         addr_log.push_back(din_sh[13:11]);
      end

   vec_t vt[NV];

   task automatic set_vals(input int k);
      v_l = vt[k].l;
      v_c = vt[k].c;
      v_r = vt[k].r;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!sensor_valid && n < 5*FRAME_CYC) begin
         @(posedge clk); #1;
         n++;
      end
      if (!sensor_valid) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: sensor_valid timeout after %0d clks, want pulse", name, n);
      end
   endtask

   initial begin
      int cnt, low, sl, c0, prev_v;
      vt[0] = '{12'd3000, 12'd200,  12'd200,  3'b100};
      vt[1] = '{12'd3000, 12'd1800, 12'd200,  3'b110};
      vt[2] = '{12'd1500, 12'd1600, 12'd200,  3'b110};
      vt[3] = '{12'd1400, 12'd1400, 12'd1800, 3'b111};
      vt[4] = '{12'd1399, 12'd1399, 12'd1799, 3'b001};
      vt[5] = '{12'd1799, 12'd1799, 12'd1399, 3'b000};
      vt[6] = '{12'd4095, 12'd0,    12'd1800, 3'b101};
      set_vals(0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", adc_cs_n, 1);
      chk("rst_sck", adc_sck, 1);
      chk("rst_din", adc_din, 0);
      chk("rst_data", adc_data, 0);
      chk("rst_valid", sensor_valid, 0);
      chk("rst_raw_l", raw_left, 0);
      chk("rst_raw_c", raw_center, 0);
      chk("rst_raw_r", raw_right, 0);

      @(negedge clk);
      rst_n = 1'b1;
      c0 = cyc;
      cnt = 0;
      while (adc_cs_n && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("cs_fall_delay", cnt, GAP_CYC);

      low = 0;
      sl  = 0;
      while (!adc_cs_n && low < 1000) begin
         if (!adc_sck) sl++;
         low++;
         @(posedge clk); #1;
      end
      chk("cs_low_clks", low, 33*CLK_DIV);
      chk("sck_low_clks", sl, 16*CLK_DIV);
      chk("sck_pulses", fall_k, 16);

      prev_v = 0;
      for (int k = 0; k < NV; k++) begin
         wait_valid("sweep");
         if (!sensor_valid) break;
         if (k == 0) begin
            chk("first_latency", cyc - c0, FIRST_LAT);
            chk("latch_cs_n", adc_cs_n, 1);
            chk("latch_din", adc_din, 0);
         end else begin
            chk("valid_interval", cyc - prev_v, 3*FRAME_CYC);
         end
         prev_v = cyc;
         chk($sformatf("v%0d_data", k), adc_data, vt[k].exp);
         chk($sformatf("v%0d_raw_l", k), raw_left, vt[k].l);
         chk($sformatf("v%0d_raw_c", k), raw_center, vt[k].c);
         chk($sformatf("v%0d_raw_r", k), raw_right, vt[k].r);
         if (k + 1 < NV) set_vals(k + 1);
         @(posedge clk); #1;
         chk($sformatf("v%0d_width", k), sensor_valid, 0);
      end

      if (addr_log.size() < 4) begin
         n_vec++;
         n_bad++;
         $display("FAIL addr_log: got %0d frames, want at least 4", addr_log.size());
      end else begin
         chk("addr_f1", addr_log[0], 0);
         chk("addr_f2", addr_log[1], 1);
         chk("addr_f3", addr_log[2], 2);
         chk("addr_f4", addr_log[3], 0);
      end

      // Abort a frame during SCK pulse 9, then expect a full dummy-frame restart
      cnt = 0;
      while (adc_cs_n && cnt < 1000) begin
         @(posedge clk); #1;
         cnt++;
      end
      cnt = 0;
      while (fall_k < 9 && cnt < 1000) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("abort_at_pulse", fall_k, 9);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_cs_n", adc_cs_n, 1);
      chk("abort_sck", adc_sck, 1);
      chk("abort_din", adc_din, 0);
      chk("abort_valid", sensor_valid, 0);
      chk("abort_data", adc_data, 0);
      chk("abort_raw_l", raw_left, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      c0 = cyc;
      wait_valid("restart");
      if (sensor_valid) begin
         chk("restart_latency", cyc - c0, FIRST_LAT);
         chk("restart_data", adc_data, 3'b101);
         chk("restart_raw_l", raw_left, 12'd4095);
         chk("restart_raw_c", raw_center, 12'd0);
         chk("restart_raw_r", raw_right, 12'd1800);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
